// File: rtl/ntt_job_scheduler_pkg.sv
// Shared FSM encoding and parameter defaults for the NTT job scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ntt_job_scheduler_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_CLEAR  = ST_CLEAR,
        S_START  = ST_START,
        S_RUN    = ST_RUN,
        S_REPORT = ST_REPORT
    } sched_state_t;

    localparam int CLR_CYCLES_DEF = 4;
    localparam int TOUT_W_DEF     = 24;

endpackage

// File: rtl/ntt_job_fifo.sv
// Small synchronous FIFO holding queued job descriptors.
// Latency: a pushed word is poppable the cycle after the push; head word is read combinationally.
// Backpressure: full derives from the registered count, so a push while full is refused even if popping.
module ntt_job_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/ntt_job_scheduler.sv
// Runs queued NTT/INTT jobs one at a time through the single-shot NTT wrapper.
// Latency: pop to start is 1+CLR_CYCLES cycles; done pulses the cycle after the final write-back.
// Backpressure: req_ready drops while the job FIFO is full; no backpressure on done.
module ntt_job_scheduler
    import ntt_job_scheduler_pkg::*;
#(
    parameter int LOGN       = 12,
    parameter int BANKW      = 3,
    parameter int TAGW       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CLR_CYCLES = CLR_CYCLES_DEF,
    parameter int TOUT_W     = TOUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_intt,
    input  logic [BANKW-1:0] req_src,
    input  logic [BANKW-1:0] req_dst,
    input  logic [TAGW-1:0]  req_tag,
    output logic             nttw_rst,
    output logic             nttw_start,
    output logic             nttw_intt,
    input  logic             nttw_wea,
    input  logic             nttw_finish,
    output logic [BANKW-1:0] src_bank,
    output logic [BANKW-1:0] dst_bank,
    output logic             done_valid,
    output logic [TAGW-1:0]  done_tag,
    output logic             done_err,
    output logic             busy,
    input  logic             abort
);

    localparam int JW = 1 + 2*BANKW + TAGW;
    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CW-1:0]  CLR_LOAD = CW'(CLR_CYCLES - 1);
    localparam logic [LOGN:0]  WR_FULL  = {1'b1, {LOGN{1'b0}}};

    sched_state_t      state;
    logic [CW-1:0]     clr_cnt;
    logic [LOGN:0]     wr_cnt;
    logic [LOGN:0]     wr_nxt;
    logic [TOUT_W-1:0] tout_cnt;
    logic [TAGW-1:0]   tag_q;
    logic              job_ok;
    logic              tout_hit;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [JW-1:0]     fifo_dat;

    ntt_job_fifo #(
        .WIDTH (JW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (req_valid && req_ready),
        .push_dat ({req_intt, req_src, req_dst, req_tag}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign req_ready = !fifo_full;
    assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
    assign busy      = (state != S_IDLE) || !fifo_empty;

    // Write count saturates so surplus write enables cannot wrap it past completion.
    assign wr_nxt   = (nttw_wea && (wr_cnt != WR_FULL)) ? wr_cnt + 1'b1 : wr_cnt;
    assign job_ok   = (wr_nxt == WR_FULL) && nttw_finish;
    assign tout_hit = &tout_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            nttw_rst   <= 1'b1;
            nttw_start <= 1'b0;
            nttw_intt  <= 1'b0;
            src_bank   <= '0;
            dst_bank   <= '0;
            done_valid <= 1'b0;
            done_tag   <= '0;
            done_err   <= 1'b0;
            clr_cnt    <= '0;
            wr_cnt     <= '0;
            tout_cnt   <= '0;
            tag_q      <= '0;
        end else begin
            nttw_start <= 1'b0;
            done_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    nttw_rst <= 1'b1;
                    if (!fifo_empty) begin
                        {nttw_intt, src_bank, dst_bank, tag_q} <= fifo_dat;
                        clr_cnt <= CLR_LOAD;
                        state   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt == '0) begin
                        nttw_rst   <= 1'b0;
                        nttw_start <= 1'b1;
                        state      <= S_START;
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                    end
                end
                S_START: begin
                    wr_cnt   <= '0;
                    tout_cnt <= '0;
                    state    <= S_RUN;
                end
                S_RUN: begin
                    wr_cnt   <= wr_nxt;
                    tout_cnt <= tout_cnt + 1'b1;
                    // A completing job wins over a simultaneous timeout or abort.
                    if (job_ok || tout_hit || abort) begin
                        nttw_rst   <= 1'b1;
                        done_valid <= 1'b1;
                        done_err   <= !job_ok;
                        done_tag   <= tag_q;
                        state      <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    nttw_rst <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    nttw_rst <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Scoreboard bench for ntt_job_scheduler with a behavioural wrapper stub driven per job profile.
module tb_ntt_job_scheduler;

    localparam int LOGN       = 12;
    localparam int BANKW      = 3;
    localparam int TAGW       = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CLR_CYCLES = 4;
    localparam int TOUT_W     = 13;
    localparam int NWR        = 1 << LOGN;
    localparam int TOUT_RUN   = (1 << TOUT_W) - 1;

    localparam int P_NORMAL = 0;
    localparam int P_SILENT = 1;
    localparam int P_ABORT  = 2;
    localparam int P_PRIO   = 3;

    // Latency from the start pulse to the done pulse, per profile.
    localparam int LAT_NORMAL = 1 + 100 + NWR;
    localparam int LAT_TOUT   = 1 + TOUT_RUN + 1;
    localparam int LAT_ABORT  = 1 + 1000 + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_intt = 1'b0;
    logic [BANKW-1:0] req_src = '0;
    logic [BANKW-1:0] req_dst = '0;
    logic [TAGW-1:0]  req_tag = '0;
    logic             nttw_rst;
    logic             nttw_start;
    logic             nttw_intt;
    logic             nttw_wea = 1'b0;
    logic             nttw_finish = 1'b0;
    logic [BANKW-1:0] src_bank;
    logic [BANKW-1:0] dst_bank;
    logic             done_valid;
    logic [TAGW-1:0]  done_tag;
    logic             done_err;
    logic             busy;
    logic             abort = 1'b0;

    always #5 clk = ~clk;

    ntt_job_scheduler #(
        .LOGN       (LOGN),
        .BANKW      (BANKW),
        .TAGW       (TAGW),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CLR_CYCLES (CLR_CYCLES),
        .TOUT_W     (TOUT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_intt    (req_intt),
        .req_src     (req_src),
        .req_dst     (req_dst),
        .req_tag     (req_tag),
        .nttw_rst    (nttw_rst),
        .nttw_start  (nttw_start),
        .nttw_intt   (nttw_intt),
        .nttw_wea    (nttw_wea),
        .nttw_finish (nttw_finish),
        .src_bank    (src_bank),
        .dst_bank    (dst_bank),
        .done_valid  (done_valid),
        .done_tag    (done_tag),
        .done_err    (done_err),
        .busy        (busy),
        .abort       (abort)
    );

    typedef struct {
        int intt;
        int src;
        int dst;
        int prof;
        bit gap;
    } start_exp_t;

    typedef struct {
        int tag;
        int err;
        int lat;
    } done_exp_t;

    start_exp_t start_q[$];
    done_exp_t  done_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_start = 0;
    int n_done = 0;
    int last_start = 0;
    int last_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor plus wrapper stub: checks every start/done pulse against the queues.
    int         prof = P_NORMAL;
    bit         active = 1'b0;
    int         r = 0;
    start_exp_t se;
    done_exp_t  de;

    always @(negedge clk) begin
        if (done_valid === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got tag %0d expected no completion", done_tag);
            end else begin
                de = done_q.pop_front();
                check("done_tag", int'(done_tag), de.tag);
                check("done_err", int'(done_err), de.err);
                check("done_latency", cyc - last_start, de.lat);
                check("report_nttw_rst", int'(nttw_rst), 1);
            end
            n_done++;
            last_done = cyc;
        end
        if (nttw_start === 1'b1) begin
            if (start_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_start: got start pulse expected none");
                prof = P_SILENT;
            end else begin
                se = start_q.pop_front();
                check("start_intt", int'(nttw_intt), se.intt);
                check("start_src_bank", int'(src_bank), se.src);
                check("start_dst_bank", int'(dst_bank), se.dst);
                check("start_nttw_rst", int'(nttw_rst), 0);
                if (se.gap) check("done_to_start_gap", cyc - last_done, CLR_CYCLES + 2);
                prof = se.prof;
            end
            n_start++;
            last_start = cyc;
            active = 1'b1;
            r = 0;
            nttw_wea = 1'b0;
            nttw_finish = 1'b0;
            abort = 1'b0;
        end else if (nttw_rst !== 1'b0) begin
            active = 1'b0;
            nttw_wea = 1'b0;
            nttw_finish = 1'b0;
            abort = 1'b0;
        end else if (active) begin
            nttw_wea = 1'b0;
            nttw_finish = 1'b0;
            abort = 1'b0;
            case (prof)
                P_NORMAL: begin
                    nttw_finish = (r >= 100);
                    nttw_wea = (r >= 100) && (r < 100 + NWR);
                end
                P_ABORT: begin
                    nttw_wea = (r < 1000);
                    abort = (r == 1000);
                end
                P_PRIO: begin
                    nttw_wea = 1'b1;
                    nttw_finish = (r == TOUT_RUN);
                end
                default: ;
            endcase
            r++;
        end
    end

    // Offers a job; expectations enter the scoreboard only once it is accepted.
    task automatic push_job(input int tag, input int intt, input int src, input int dst,
                            input int pf, input int err, input int lat, input bit gap,
                            input int budget, output int acc_cyc);
        int waited;
        start_exp_t s;
        done_exp_t d;
        waited = 0;
        req_valid = 1'b1;
        req_tag = TAGW'(tag);
        req_intt = intt[0];
        req_src = BANKW'(src);
        req_dst = BANKW'(dst);
        while (req_ready !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        acc_cyc = cyc;
        if (req_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: tag %0d got req_ready=0 expected 1 within %0d cycles", tag, budget);
            req_valid = 1'b0;
        end else begin
            s.intt = intt; s.src = src; s.dst = dst; s.prof = pf; s.gap = gap;
            d.tag = tag; d.err = err; d.lat = lat;
            start_q.push_back(s);
            done_q.push_back(d);
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (n_done < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_done_count", n_done, n);
    endtask

    task automatic wait_start(input int n, input int budget);
        int k;
        k = 0;
        while (n_start < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_start_count", n_start, n);
    endtask

    int acc;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_nttw_rst", int'(nttw_rst), 1);
        check("reset_nttw_start", int'(nttw_start), 0);
        check("reset_nttw_intt", int'(nttw_intt), 0);
        check("reset_src_bank", int'(src_bank), 0);
        check("reset_dst_bank", int'(dst_bank), 0);
        check("reset_done_valid", int'(done_valid), 0);
        check("reset_done_tag", int'(done_tag), 0);
        check("reset_done_err", int'(done_err), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_req_ready", int'(req_ready), 1);

        // Single job.
        push_job(5, 0, 1, 2, P_NORMAL, 0, LAT_NORMAL, 1'b0, 10, acc);
        check("busy_while_job", int'(busy), 1);
        wait_done(1, LAT_NORMAL + 50);

        // Timeout job, with four more filling the FIFO behind it and a fifth held off.
        push_job(6, 1, 3, 4, P_SILENT, 1, LAT_TOUT, 1'b0, 10, acc);
        wait_start(2, 50);
        push_job(1, 0, 2, 3, P_NORMAL, 0, LAT_NORMAL, 1'b1, 10, acc);
        push_job(2, 1, 4, 5, P_NORMAL, 0, LAT_NORMAL, 1'b1, 10, acc);
        push_job(3, 0, 6, 7, P_NORMAL, 0, LAT_NORMAL, 1'b1, 10, acc);
        push_job(4, 1, 7, 1, P_NORMAL, 0, LAT_NORMAL, 1'b1, 10, acc);
        check("full_req_ready", int'(req_ready), 0);
        push_job(7, 0, 5, 5, P_NORMAL, 0, LAT_NORMAL, 1'b1, LAT_TOUT + 50, acc);
        check("ready_two_after_done", acc - last_done, 2);
        wait_done(7, LAT_TOUT + 5 * (LAT_NORMAL + 10) + 100);

        // Abort mid-run, then a normal job that must need the full write count again.
        push_job(8, 1, 5, 6, P_ABORT, 1, LAT_ABORT, 1'b0, 10, acc);
        push_job(9, 0, 7, 0, P_NORMAL, 0, LAT_NORMAL, 1'b1, 10, acc);
        wait_done(9, LAT_ABORT + LAT_NORMAL + 100);

        // Completion coinciding with timeout expiry, surplus writes throughout.
        push_job(10, 1, 2, 5, P_PRIO, 0, LAT_TOUT, 1'b0, 10, acc);
        wait_done(10, LAT_TOUT + 50);

        // Reset in the middle of a run with two jobs still queued.
        push_job(11, 0, 1, 1, P_NORMAL, 0, LAT_NORMAL, 1'b0, 10, acc);
        wait_start(11, 50);
        push_job(12, 1, 3, 3, P_NORMAL, 0, LAT_NORMAL, 1'b0, 10, acc);
        push_job(13, 0, 4, 4, P_NORMAL, 0, LAT_NORMAL, 1'b0, 10, acc);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_q.delete();
        done_q.delete();
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_req_ready", int'(req_ready), 1);
        check("midrst_nttw_rst", int'(nttw_rst), 1);
        check("midrst_done_valid", int'(done_valid), 0);
        repeat (30) @(negedge clk);
        check("midrst_no_done", n_done, 10);
        check("midrst_no_start", n_start, 11);
        check("midrst_idle_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
